// File: rtl/spike_rate_monitor_pkg.sv
// Shared definitions for the spike rate monitor: FSM state encoding and
// the default counter width.
package spike_rate_monitor_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int CNT_W_DEF = 8;

endpackage : spike_rate_monitor_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment,
// so a clear and an increment in the same cycle restart the count at 0.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

   // Count up on inc, hold at all-ones, restart on reset or clear.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && (count != MAX_VAL)) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts spikes from an upstream LIF neuron over a
// window of N cycles and presents each window's count on a valid/ready
// output. Optional inter-spike-interval measurement is built when the
// macro SPIKE_MON_ISI_EN is defined; otherwise isi_last is tied to 0.
//
// Output handshake: a result moves to the consumer on any rising edge where
// out_valid and out_ready are both 1. out_valid never waits for out_ready;
// rate_count is held while a result is pending, except that a newer window
// result overwrites it (setting the sticky overrun flag if the pending one
// was not being accepted on that same edge).
module spike_rate_monitor
   import spike_rate_monitor_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spike,
   input  logic             enable,
   input  logic [CNT_W-1:0] window_len,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] rate_count,
   output logic [CNT_W-1:0] isi_last,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_next;
   logic             active;     // a counting RUN cycle
   logic             load_len;   // sample window_len this cycle
   logic             win_end;    // last cycle of the current window
   logic             cnt_clear;
   logic [CNT_W-1:0] n_len;      // current window length, never 0
   logic [CNT_W-1:0] win_cnt;
   logic [CNT_W-1:0] spike_cnt;
   logic [CNT_W-1:0] rate_new;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: enable alone moves between IDLE and RUN.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable)  state_next = RUN;
         RUN:     if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: a RUN cycle with enable low is the exit cycle and does not
   // count; window_len is sampled on the cycle that moves IDLE to RUN.
   always_comb begin
      active   = 1'b0;
      load_len = 1'b0;
      case (state)
         IDLE:    load_len = enable;
         RUN:     active   = enable;
         default: ;
      endcase
   end

   assign win_end   = active && (win_cnt == (n_len - CNT_ONE));
   // Counters sit at 0 outside RUN and restart at 0 right after a window end.
   assign cnt_clear = !active || win_end;

   // Result for the closing window includes this cycle's spike, saturating.
   assign rate_new = (spike && (spike_cnt != CNT_MAX)) ? spike_cnt + CNT_ONE : spike_cnt;

   // Window length register: a 0 request is treated as 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_len <= CNT_ONE;
      end else if (load_len || win_end) begin
         n_len <= (window_len == '0) ? CNT_ONE : window_len;
      end
   end

   sat_counter #(.W(CNT_W)) u_win_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (active),
      .count (win_cnt)
   );

   sat_counter #(.W(CNT_W)) u_spike_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (active && spike),
      .count (spike_cnt)
   );

   // Result register, valid flag and sticky overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         rate_count <= '0;
         overrun    <= 1'b0;
      end else if (win_end) begin
         rate_count <= rate_new;
         out_valid  <= 1'b1;
         if (out_valid && !out_ready) begin
            overrun <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef SPIKE_MON_ISI_EN
   logic [CNT_W-1:0] isi_cnt;
   logic [CNT_W-1:0] isi_reg;

   // Free-running interval counter; a spike restarts it at 0.
   sat_counter #(.W(CNT_W)) u_isi_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (spike),
      .inc   (1'b1),
      .count (isi_cnt)
   );

   // Capture the elapsed interval (counter + 1, saturating) on each spike.
   always_ff @(posedge clk) begin
      if (reset) begin
         isi_reg <= '0;
      end else if (spike) begin
         isi_reg <= (isi_cnt != CNT_MAX) ? isi_cnt + CNT_ONE : isi_cnt;
      end
   end

   assign isi_last = isi_reg;
`else
   assign isi_last = '0;
`endif

endmodule : spike_rate_monitor

// File: doc/spike_rate_monitor.md
SPIKE_RATE_MONITOR -- requirements
Module: spike_rate_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the spike counter, the window counter and the ISI counter.
REQ-002 The block SHALL have port clk, input, 1 bit: clock.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port spike, input, 1 bit: registered spike level from the upstream LIF neuron; one high cycle is one spike.
REQ-005 The block SHALL have port enable, input, 1 bit: run monitoring.
REQ-006 The block SHALL have port window_len, input, CNT_W bits: window length N in cycles; 0 is treated as 1.
REQ-007 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a result is pending.
REQ-009 The block SHALL have port rate_count, output, CNT_W bits: spikes counted in the completed window.
REQ-010 The block SHALL have port isi_last, output, CNT_W bits: cycles between the last two spikes.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a result was lost.

Function
REQ-012 The FSM SHALL have two states, IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-013 On entering IDLE, the partial window SHALL be discarded and the window and spike counters cleared; any pending result SHALL be retained.
REQ-014 window_len SHALL be sampled on IDLE->RUN and at each window end; changes mid-window SHALL take effect at the next window.
REQ-015 In RUN, each cycle with spike=1 SHALL increment the spike counter, saturating at 2^CNT_W-1.
REQ-016 On the Nth RUN cycle, rate_count SHALL load the count including that cycle's spike, out_valid SHALL go 1 on the next edge, and the next window SHALL start with no gap cycles.
REQ-017 Handshake: the result SHALL transfer when out_valid and out_ready are both 1; out_valid SHALL then drop next cycle unless a new result lands that same cycle.
REQ-018 rate_count SHALL stay stable while out_valid=1 and the result is unaccepted, except as stated in REQ-019.
REQ-019 At a window end with out_valid=1 and out_ready=0, the new result SHALL overwrite rate_count, out_valid SHALL stay 1, and overrun SHALL set.
REQ-020 At a window end coincident with an accepting handshake, the new result SHALL load, out_valid SHALL stay 1, and overrun SHALL not set.
REQ-021 overrun SHALL clear only on reset.

Reset
REQ-022 While reset=1, the FSM SHALL be IDLE, all counters 0, out_valid=0, rate_count=0, isi_last=0, and overrun=0.
REQ-023 Reset mid-window SHALL discard the window and any pending result; reset SHALL take priority over all other inputs.

Configuration
REQ-024 With SPIKE_MON_ISI_EN defined, the ISI counter SHALL increment every cycle, saturating, in both RUN and IDLE.
REQ-025 With SPIKE_MON_ISI_EN defined, on each spike isi_last SHALL load the counter value +1 (saturating) and the counter SHALL restart at 0; the first spike after reset SHALL load the saturated or elapsed value.
REQ-026 With SPIKE_MON_ISI_EN undefined, isi_last SHALL be constant 0 and no ISI register SHALL be synthesised.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef (IDLE/RUN) and the default CNT_W constant.
REQ-028 A single sub-module, sat_counter (parameterised width, increment, clear, saturating), SHALL be used for the spike, window and ISI counters.

Verification
REQ-029 reset; enable=1, window_len=10, spike high for 3 cycles in the window -> out_valid=1 after cycle 10, rate_count=3.
REQ-030 window_len=4, out_ready=0 for two windows with 1 then 2 spikes -> rate_count=2, overrun=1, out_valid=1.
REQ-031 window_len=4, out_ready=1 exactly on the second window end -> first result accepted, second loaded, out_valid stays 1, overrun=0.
REQ-032 window_len=0, spike constant 1 -> a result every cycle with rate_count=1.
REQ-033 window_len=255, spike constant 1 -> rate_count=255 with no wrap.
REQ-034 With SPIKE_MON_ISI_EN: spikes at cycles 5 and 12 -> isi_last=7; enable dropped mid-window then raised -> the new window counts from 0 and the pending result is unchanged.
